// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet frame checker.
package eth_pkg;

   typedef enum logic [1:0] {
      ERR_OK    = 2'd0,
      ERR_RUNT  = 2'd1,
      ERR_GIANT = 2'd2,
      ERR_PROTO = 2'd3
   } err_code_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_FRAME = 2'd1,
      DROP     = 2'd2
   } chk_state_t;

   // Internal word layout: {eop, sop, data[63:0]}
   localparam int WORD_W  = 66;
   localparam int SOP_BIT = 64;
   localparam int EOP_BIT = 65;

   localparam int DEF_MIN_WORDS = 8;
   localparam int DEF_MAX_WORDS = 190;

endpackage

// File: rtl/eth_stat_counter.sv
// Saturating statistics counter with synchronous clear that wins over increment.
// Single-cycle update, no flow control.
module eth_stat_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 inc,
   input  logic                 clr,
   output logic [CNT_WIDTH-1:0] cnt
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != {CNT_WIDTH{1'b1}}))
         cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/eth_frame_checker.sv
// Validates sop/eop framing and frame length, forcing eop and tagging an error code on bad frames.
// Fixed 2-cycle latency (S1 + output register); no backpressure, bubbles pass as outVld = 0.
module eth_frame_checker
   import eth_pkg::*;
#(
   parameter int MIN_WORDS = DEF_MIN_WORDS,
   parameter int MAX_WORDS = DEF_MAX_WORDS,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic [63:0]          inData,
   input  logic                 inSop,
   input  logic                 inEop,
   input  logic                 inVld,
   input  logic                 clrStats,
   output logic [63:0]          outData,
   output logic                 outSop,
   output logic                 outEop,
   output logic                 outVld,
   output logic                 outErr,
   output logic [1:0]           outErrCode,
   output logic [CNT_WIDTH-1:0] goodFrames,
   output logic [CNT_WIDTH-1:0] runtFrames,
   output logic [CNT_WIDTH-1:0] giantFrames,
   output logic [CNT_WIDTH-1:0] protoErrs
);

   localparam int WCNT_W = $clog2(MAX_WORDS + 2);
   localparam logic [1:0] ST_IDLE     = IDLE;
   localparam logic [1:0] ST_IN_FRAME = IN_FRAME;
   localparam logic [1:0] ST_DROP     = DROP;

   logic [1:0]        state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              s1_vld_q, s1_vld_d;
   logic [WORD_W-1:0] s1_word_q, s1_word_d;
   err_code_t         s1_code_q, s1_code_d;
   logic              out_vld_q, out_vld_d;
   logic [WORD_W-1:0] out_word_q, out_word_d;
   err_code_t         out_code_q, out_code_d;

   logic              take, entry, force_eop, stray, ld_eop;
   err_code_t         take_code, force_code;
   logic              inc_good, inc_runt, inc_giant, inc_proto;

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      take       = 1'b0;
      entry      = 1'b0;
      take_code  = ERR_OK;
      force_eop  = 1'b0;
      force_code = ERR_OK;
      stray      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (inVld) begin
               if (inSop) entry = 1'b1;
               else       stray = 1'b1;
            end
         end
         ST_IN_FRAME: begin
            if (!inVld) begin
               force_eop  = 1'b1;
               force_code = ERR_PROTO;
               state_d    = ST_IDLE;
            end else if (inSop) begin
               force_eop  = 1'b1;
               force_code = ERR_PROTO;
               entry      = 1'b1;
            end else if (wcnt_q == WCNT_W'(MAX_WORDS)) begin
               // Any word past the maximum overflows; an eop here still ends the frame.
               force_eop  = 1'b1;
               force_code = ERR_GIANT;
               state_d    = inEop ? ST_IDLE : ST_DROP;
            end else begin
               take   = 1'b1;
               wcnt_d = wcnt_q + WCNT_W'(1);
               if (inEop) begin
                  take_code = ((wcnt_q + WCNT_W'(1)) < WCNT_W'(MIN_WORDS)) ? ERR_RUNT : ERR_OK;
                  state_d   = ST_IDLE;
               end
            end
         end
         ST_DROP: begin
            if (!inVld)      state_d = ST_IDLE;
            else if (inSop)  entry   = 1'b1;
            else if (inEop)  state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (entry) begin
         take   = 1'b1;
         wcnt_d = WCNT_W'(1);
         if (inEop) begin
            take_code = (MIN_WORDS > 1) ? ERR_RUNT : ERR_OK;
            state_d   = ST_IDLE;
         end else begin
            state_d   = ST_IN_FRAME;
         end
      end

      s1_vld_d  = take;
      s1_word_d = take ? {inEop, inSop, inData} : '0;
      s1_code_d = take ? take_code : ERR_OK;

      out_vld_d           = s1_vld_q;
      out_word_d          = s1_word_q;
      out_word_d[EOP_BIT] = s1_word_q[EOP_BIT] | force_eop;
      if (force_eop)               out_code_d = force_code;
      else if (s1_word_q[EOP_BIT]) out_code_d = s1_code_q;
      else                         out_code_d = ERR_OK;

      ld_eop    = s1_vld_q & out_word_d[EOP_BIT];
      inc_good  = ld_eop & (out_code_d == ERR_OK);
      inc_runt  = ld_eop & (out_code_d == ERR_RUNT);
      inc_giant = ld_eop & (out_code_d == ERR_GIANT);
      inc_proto = (ld_eop & (out_code_d == ERR_PROTO)) | stray;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= ST_IDLE;
         wcnt_q     <= '0;
         s1_vld_q   <= 1'b0;
         s1_word_q  <= '0;
         s1_code_q  <= ERR_OK;
         out_vld_q  <= 1'b0;
         out_word_q <= '0;
         out_code_q <= ERR_OK;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         s1_vld_q   <= s1_vld_d;
         s1_word_q  <= s1_word_d;
         s1_code_q  <= s1_code_d;
         out_vld_q  <= out_vld_d;
         out_word_q <= out_word_d;
         out_code_q <= out_code_d;
      end
   end

   assign outData    = out_word_q[63:0];
   assign outSop     = out_word_q[SOP_BIT];
   assign outEop     = out_word_q[EOP_BIT];
   assign outVld     = out_vld_q;
   assign outErrCode = out_code_q;
   assign outErr     = (out_code_q != ERR_OK);

   eth_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_good (
      .clk(clk), .resetN(resetN), .inc(inc_good), .clr(clrStats), .cnt(goodFrames));
   eth_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_runt (
      .clk(clk), .resetN(resetN), .inc(inc_runt), .clr(clrStats), .cnt(runtFrames));
   eth_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_giant (
      .clk(clk), .resetN(resetN), .inc(inc_giant), .clr(clrStats), .cnt(giantFrames));
   eth_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_proto (
      .clk(clk), .resetN(resetN), .inc(inc_proto), .clr(clrStats), .cnt(protoErrs));

endmodule

// File: tb/tb_eth_frame_checker.sv
// Directed bench for eth_frame_checker: per-cycle vector table plus hand sequences for clear and reset.
module tb_eth_frame_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetN, inSop, inEop, inVld, clrStats;
   logic [63:0] inData;

   logic [63:0] outData;
   logic        outSop, outEop, outVld, outErr;
   logic [1:0]  outErrCode;
   logic [31:0] goodFrames, runtFrames, giantFrames, protoErrs;

   logic [63:0] s_outData;
   logic        s_outSop, s_outEop, s_outVld, s_outErr;
   logic [1:0]  s_outErrCode;
   logic [1:0]  s_good, s_runt, s_giant, s_proto;

   eth_frame_checker #(.MIN_WORDS(8), .MAX_WORDS(190), .CNT_WIDTH(32)) dut (
      .clk(clk), .resetN(resetN), .inData(inData), .inSop(inSop), .inEop(inEop),
      .inVld(inVld), .clrStats(clrStats), .outData(outData), .outSop(outSop),
      .outEop(outEop), .outVld(outVld), .outErr(outErr), .outErrCode(outErrCode),
      .goodFrames(goodFrames), .runtFrames(runtFrames), .giantFrames(giantFrames),
      .protoErrs(protoErrs));

   eth_frame_checker #(.MIN_WORDS(8), .MAX_WORDS(190), .CNT_WIDTH(2)) dut_sat (
      .clk(clk), .resetN(resetN), .inData(inData), .inSop(inSop), .inEop(inEop),
      .inVld(inVld), .clrStats(clrStats), .outData(s_outData), .outSop(s_outSop),
      .outEop(s_outEop), .outVld(s_outVld), .outErr(s_outErr), .outErrCode(s_outErrCode),
      .goodFrames(s_good), .runtFrames(s_runt), .giantFrames(s_giant),
      .protoErrs(s_proto));

   typedef struct {
      logic        vld, sop, eop;
      logic [63:0] data;
      logic        e_vld, e_sop, e_eop;
      logic [1:0]  e_code;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void push(input logic v, input logic s, input logic e, input logic [63:0] d,
                                input logic ev, input logic es, input logic ee, input logic [1:0] ec);
      vec_t r;
      r.vld = v; r.sop = s; r.eop = e; r.data = d;
      r.e_vld = ev; r.e_sop = es; r.e_eop = ee; r.e_code = ec;
      tbl.push_back(r);
   endfunction

   function automatic void add_frame(input int n, input logic [63:0] base, input logic [1:0] code);
      for (int i = 0; i < n; i++)
         push(1'b1, i == 0, i == n - 1, base + 64'(i),
              1'b1, i == 0, i == n - 1, (i == n - 1) ? code : 2'd0);
   endfunction

   function automatic void idle(input int n);
      for (int i = 0; i < n; i++)
         push(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 2'd0);
   endfunction

   task automatic drive(input logic v, input logic s, input logic e, input logic [63:0] d, input logic c);
      inVld = v; inSop = s; inEop = e; inData = d; clrStats = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check_row(input int j);
      logic [127:0] act, exp;
      if (tbl[j].e_vld) begin
         act = {58'd0, outVld, outSop, outEop, outErr, outErrCode, outData};
         exp = {58'd0, 1'b1, tbl[j].e_sop, tbl[j].e_eop,
                tbl[j].e_eop & (tbl[j].e_code != 2'd0),
                tbl[j].e_eop ? tbl[j].e_code : 2'd0, tbl[j].data};
      end else begin
         act = {127'd0, outVld};
         exp = '0;
      end
      chk($sformatf("row%0d", j), act, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      resetN = 1'b0; inVld = 1'b0; inSop = 1'b0; inEop = 1'b0; inData = '0; clrStats = 1'b0;

      add_frame(8, 64'h1, 2'd0);            idle(2);
      add_frame(3, 64'h11, 2'd1);           idle(1);
      push(1, 1, 1, 64'h60, 1, 1, 1, 2'd1); idle(1);
      // Gap after word 4 truncates the frame.
      push(1, 1, 0, 64'h21, 1, 1, 0, 2'd0);
      push(1, 0, 0, 64'h22, 1, 0, 0, 2'd0);
      push(1, 0, 0, 64'h23, 1, 0, 0, 2'd0);
      push(1, 0, 0, 64'h24, 1, 0, 1, 2'd3); idle(2);
      // A new sop at word 6 truncates word 5.
      push(1, 1, 0, 64'h31, 1, 1, 0, 2'd0);
      for (int i = 2; i <= 4; i++) push(1, 0, 0, 64'h30 + 64'(i), 1, 0, 0, 2'd0);
      push(1, 0, 0, 64'h35, 1, 0, 1, 2'd3);
      add_frame(8, 64'h41, 2'd0);           idle(1);
      push(1, 0, 0, 64'h55, 0, 0, 0, 2'd0); idle(2);
      add_frame(190, 64'h1000, 2'd0);       idle(1);
      for (int i = 0; i < 200; i++) begin
         if (i < 190)
            push(1, i == 0, i == 199, 64'h2000 + 64'(i), 1, i == 0, i == 189, (i == 189) ? 2'd2 : 2'd0);
         else
            push(1, 0, i == 199, 64'h2000 + 64'(i), 0, 0, 0, 2'd0);
      end
      idle(1);
      add_frame(8, 64'h3000, 2'd0);         idle(3);

      @(posedge clk); #1;
      chk("reset_outputs", {58'd0, outData, outSop, outEop, outVld, outErr, outErrCode}, '0);
      chk("reset_counters", {goodFrames, runtFrames, giantFrames, protoErrs}, '0);
      chk("reset_sat_counters", {120'd0, s_good, s_runt, s_giant, s_proto}, '0);
      @(posedge clk); #1;
      resetN = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         inVld = tbl[i].vld; inSop = tbl[i].sop; inEop = tbl[i].eop; inData = tbl[i].data;
         @(posedge clk);
         #1;
         if (i > 0) check_row(i - 1);
      end

      chk("good_frames", {96'd0, goodFrames}, 128'd4);
      chk("runt_frames", {96'd0, runtFrames}, 128'd2);
      chk("giant_frames", {96'd0, giantFrames}, 128'd1);
      chk("proto_errs", {96'd0, protoErrs}, 128'd3);
      chk("sat_counters", {120'd0, s_good, s_runt, s_giant, s_proto}, {120'd0, 2'd3, 2'd2, 2'd1, 2'd3});

      // Clear coincides with the edge that loads the eop into the output register.
      for (int i = 0; i < 8; i++) drive(1, i == 0, i == 7, 64'h4000 + 64'(i), 0);
      drive(0, 0, 0, 64'd0, 1);
      chk("clr_eop_present", {127'd0, outEop}, 128'd1);
      chk("clr_counters", {goodFrames, runtFrames, giantFrames, protoErrs}, '0);
      chk("clr_sat_counters", {120'd0, s_good, s_runt, s_giant, s_proto}, '0);
      drive(0, 0, 0, 64'd0, 0);
      for (int i = 0; i < 8; i++) drive(1, i == 0, i == 7, 64'h5000 + 64'(i), 0);
      drive(0, 0, 0, 64'd0, 0);
      drive(0, 0, 0, 64'd0, 0);
      chk("good_after_clr", {96'd0, goodFrames}, 128'd1);
      chk("sat_good_after_clr", {126'd0, s_good}, 128'd1);

      drive(1, 1, 0, 64'h71, 0);
      drive(1, 0, 0, 64'h72, 0);
      drive(1, 0, 0, 64'h73, 0);
      chk("pre_reset_word", {63'd0, outVld, outData}, {63'd0, 1'b1, 64'h72});
      inVld = 1'b0; inSop = 1'b0; inEop = 1'b0; inData = '0;
      #2 resetN = 1'b0;
      #1;
      chk("midreset_outputs", {58'd0, outData, outSop, outEop, outVld, outErr, outErrCode}, '0);
      chk("midreset_counters", {goodFrames, runtFrames, giantFrames, protoErrs}, '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      resetN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 64'd0, 0);
         chk($sformatf("post_reset_quiet%0d", i), {126'd0, outVld, outEop}, '0);
      end
      chk("post_reset_counters", {goodFrames, runtFrames, giantFrames, protoErrs}, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/eth_frame_checker.md
# eth_frame_checker

Frame integrity checker placed directly downstream of `eth_sw`, consuming its `outDataA`/`outSopA`/`outEopA`/`outvld` word stream. It validates the framing protocol and frame length in 64-bit words. It forwards frames with a fixed 2-cycle latency, tags each frame's last word with an error code, and maintains saturating statistics counters.

## Interface
- `MIN_WORDS`, 8, minimum legal frame length in words (64 B).
- `MAX_WORDS`, 190, maximum legal frame length in words (1518 B rounded up).
- `CNT_WIDTH`, 32, width of each statistics counter.
- `clk` in 1: clock; all logic on posedge.
- `resetN` in 1: reset, asynchronous, active-low.
- `inData` in 64: data word.
- `inSop` in 1: first word of frame.
- `inEop` in 1: last word of frame.
- `inVld` in 1: word valid; must stay high for every word from sop through eop.
- `clrStats` in 1: synchronous clear of all counters.
- `outData` out 64: forwarded word.
- `outSop` out 1: forwarded sop.
- `outEop` out 1: forwarded or forced eop.
- `outVld` out 1: output word valid.
- `outErr` out 1: frame error; valid only with `outEop`.
- `outErrCode` out 2: error code; 0 OK, 1 RUNT, 2 GIANT, 3 PROTO; valid only with `outEop`.
- `goodFrames`, `runtFrames`, `giantFrames`, `protoErrs` out CNT_WIDTH each: statistics counters.

## Operation
- Pipeline:
  - Stage S1 registers the input word.
  - The output register loads S1 each cycle, modified by the decision made on the current input.
  - Bubbles (`inVld` = 0) propagate as `outVld` = 0.
- Word counter `wcnt` has width $clog2(MAX_WORDS+2). It is set to 1 on sop and increments on each valid in-frame word.
- FSM states are IDLE, IN_FRAME and DROP.
- IDLE:
  - `inVld & inSop & inEop`: single-word frame, forwarded. RUNT if MIN_WORDS > 1, otherwise OK.
  - `inVld & inSop`: go to IN_FRAME.
  - `inVld & !inSop`: stray word. It is discarded (never reaches S1) and `protoErrs` increments.
- IN_FRAME:
  - `inVld & inEop & !inSop`: forwarded. Code RUNT if `wcnt+1 < MIN_WORDS`, otherwise OK. Go to IDLE.
  - `!inVld`: truncation. The S1 word is output with `outEop` = 1, code PROTO. Go to IDLE.
  - `inVld & inSop`: truncation. The S1 word is output with `outEop` = 1, code PROTO. The new sop is accepted and the FSM stays in IN_FRAME with `wcnt` = 1.
  - Word MAX_WORDS+1 arrives without eop: the S1 word (word MAX_WORDS) is output with `outEop` = 1, code GIANT. The incoming word is discarded. Go to DROP.
  - Eop on word MAX_WORDS exactly is legal.
- DROP:
  - All valid words are discarded, including the terminating eop.
  - Exit to IDLE on `inVld & inEop`, or on `!inVld`.
  - `inVld & inSop` in DROP: exit DROP and take the IN_FRAME entry path.
- Counters:
  - Exactly one counter increments per forwarded eop, selected by the code: OK → `goodFrames`, RUNT → `runtFrames`, GIANT → `giantFrames`, PROTO → `protoErrs`. Stray words also increment `protoErrs`.
  - Counters saturate at all-ones.
  - `clrStats` overrides a same-cycle increment; the counter reads 0 the next cycle.
  - Two increments to `protoErrs` in one cycle (truncation by sop, and stray word) are impossible by construction.

## Timing
- Latency from input word at edge t to the output at edge t+2. Fixed; no backpressure.
- Forced eop from truncation or GIANT appears on the cycle the truncated or last-kept word would have appeared. It never adds a cycle.
- `outErr` and `outErrCode` are 0 whenever `outEop` = 0.
- Reset values: every output is 0, all counters are 0, and the FSM is IDLE.
- Reset mid-frame flushes S1 and the output register. No eop is emitted for the interrupted frame and no counter changes.
- Counters update on the same edge on which the corresponding eop word is loaded into the output register.

## Structure
- `eth_pkg` holds:
  - `err_code_t` enum (OK/RUNT/GIANT/PROTO).
  - `chk_state_t` enum (IDLE/IN_FRAME/DROP).
  - Word-format constants: SOP bit 64, EOP bit 65 for the 66-bit internal word.
  - Default MIN_WORDS/MAX_WORDS.
- Sub-module `eth_stat_counter` (CNT_WIDTH, `inc`, `clr`, saturating) is instantiated four times.

## Test plan
- Good frame: 8-word frame with `inData` = 1..8 → outputs appear 2 cycles later unchanged, code 0; `goodFrames` = 1.
- Runt: 3-word frame → `outEop` on word 3 with `outErr` = 1 and code 1; `runtFrames` = 1.
- Giant and drop: 200 contiguous words with MAX_WORDS = 190 → 190 words forwarded, word 190 with `outEop` = 1 and code 2, words 191–200 absent; `giantFrames` = 1; a following 8-word frame passes OK.
- Truncation by valid gap: 5-word frame with `inVld` low after word 4 → word 4 output with `outEop` = 1 and code 3; `protoErrs` = 1.
- Truncation by sop plus stray word: a second sop at word 6 → word 5 forced eop with code 3, new frame continues normally; a stray non-sop word in IDLE → not forwarded, `protoErrs` increments.
- Saturation, clear and reset:
  - With CNT_WIDTH = 2, 5 good frames → `goodFrames` = 3.
  - `clrStats` coincident with an eop → counter reads 0.
  - `resetN` low mid-frame → all outputs 0 immediately, no eop emitted.
